// File: rtl/y86_pkg.sv
// Shared types and constants for the Y86 memory arbiter: FSM states,
// the error read-data pattern and the owner encoding.
package y86_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/y86_mem_arbiter_prio.sv
// Fixed-priority selector: the core (M0) wins unless the debug/DMA port (M1)
// has been passed over STARVE_MAX times in a row, or M0 is not requesting.
module y86_arb_prio
  import y86_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          grant
);

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  always_comb begin
    grant = OWNER_M0;
    if (m1_req && (!m0_req || (starve_cnt == STARVE_LIM))) begin
      grant = OWNER_M1;
    end
  end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Two-master memory arbiter for the Y86 core and a debug/DMA port, with
// starvation protection for M1 and an access timeout that reports an error.
module y86_mem_arbiter
  import y86_pkg::*;
#(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_done,
  output logic        m0_err,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] STARVE_LIM   = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE   = SW'(1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMEOUT_ONE  = TW'(1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [SW-1:0] starveCnt_q, starveCnt_d;
  logic [TW-1:0] timeoutCnt_q, timeoutCnt_d;
  logic          grant;

  y86_arb_prio #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_prio (
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .starve_cnt (starveCnt_q),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_M0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      starveCnt_q  <= '0;
      timeoutCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      starveCnt_q  <= starveCnt_d;
      timeoutCnt_q <= timeoutCnt_d;
    end
  end

  // Requests are only sampled in IDLE; once latched, the transaction runs to
  // completion from the held copies even if the master drops or changes them.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    starveCnt_d  = starveCnt_q;
    timeoutCnt_d = timeoutCnt_q;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d      = grant;
          err_d        = 1'b0;
          timeoutCnt_d = '0;
          state_d      = ACCESS;
          if (grant == OWNER_M1) begin
            we_d        = m1_we;
            addr_d      = m1_addr;
            wdata_d     = m1_wdata;
            starveCnt_d = '0;
          end else begin
            we_d    = m0_we;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            if (m1_req && (starveCnt_q != STARVE_LIM)) begin
              starveCnt_d = starveCnt_q + STARVE_ONE;
            end
          end
        end
      end

      // An ack on the final permitted cycle still counts as a normal completion.
      ACCESS: begin
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timeoutCnt_q == TIMEOUT_LAST) begin
          timeoutCnt_d = timeoutCnt_q + TIMEOUT_ONE;
          err_d        = 1'b1;
          rdata_d      = ERR_DATA;
          state_d      = DONE;
        end else begin
          timeoutCnt_d = timeoutCnt_q + TIMEOUT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign m0_done = (state_q == DONE) && (owner_q == OWNER_M0);
  assign m1_done = (state_q == DONE) && (owner_q == OWNER_M1);
  assign m0_err  = m0_done && err_q;
  assign m1_err  = m1_done && err_q;

  assign rdata = rdata_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Scoreboard bench for y86_mem_arbiter: directed scenarios push expected
// completions into a queue and a monitor checks each done pulse against it.
module tb_y86_mem_arbiter;

  typedef struct packed {
    logic        master;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        owner;

  logic        ackImmediate;
  logic        ackManual;
  logic [31:0] memRdata;

  exp_t expQ[$];
  int   checkCount = 0;
  int   failCount  = 0;

  y86_mem_arbiter #(.TIMEOUT(15), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m0_done   (m0_done),
    .m0_err    (m0_err),
    .m1_done   (m1_done),
    .m1_err    (m1_err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  // Memory model: either acks every strobe immediately or follows a manual pin.
  assign mem_ack   = ackImmediate ? mem_req : ackManual;
  assign mem_rdata = memRdata;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic master, input logic err, input logic [31:0] data);
    exp_t e;
    e.master = master;
    e.err    = err;
    e.rdata  = data;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m0_done || m1_done) begin
      if (m0_done && m1_done) begin
        checkOutput("dual_done", {30'b0, m1_done, m0_done}, 32'h1);
      end
      if (expQ.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL unexpected_done: got m0_done=%0b m1_done=%0b, required no completion",
                 m0_done, m1_done);
      end else begin
        e = expQ.pop_front();
        checkOutput("done_master", {31'b0, m1_done}, {31'b0, e.master});
        checkOutput("done_err", {31'b0, (m1_done ? m1_err : m0_err)}, {31'b0, e.err});
        checkOutput("nonowner_err", {31'b0, (m1_done ? m0_err : m1_err)}, 32'h0);
        checkOutput("done_rdata", rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int reqCycles;
    bit seen;

    rst = 1'b1;
    ackImmediate = 1'b0;
    ackManual    = 1'b0;
    memRdata     = 32'h0;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("reset_m0_done", {31'b0, m0_done}, 32'h0);
    checkOutput("reset_m1_done", {31'b0, m1_done}, 32'h0);
    checkOutput("reset_owner", {31'b0, owner}, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);

    // Scenario 1: single M0 load, acked in the first ACCESS cycle.
    @(posedge clk); #1;
    rst = 1'b0;
    ackImmediate = 1'b1;
    memRdata = 32'h1234_5678;
    applyStimulus(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0);
    pushExp(0, 0, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    checkOutput("s1_mem_req", {31'b0, mem_req}, 32'h1);
    checkOutput("s1_mem_addr", mem_addr, 32'h100);
    @(negedge clk);
    checkOutput("s1_done_cycle3", {31'b0, m0_done}, 32'h1);
    m0_req = 1'b0;

    // Scenario 2: both masters held; M1 must get every fifth grant.
    @(negedge clk);
    memRdata = 32'hCAFE_0001;
    applyStimulus(1, 0, 32'h104, 32'h0, 1, 0, 32'h204, 32'h0);
    for (int i = 0; i < 10; i++) pushExp((i % 5) == 4, 0, 32'hCAFE_0001);
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (m0_done || m1_done) n++;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    checkOutput("s2_done_count", n, 10);

    // Scenario 3: M1 store with no ack times out; request dropped mid-way.
    ackImmediate = 1'b0;
    @(negedge clk);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'hDEAD_BEEF);
    pushExp(1, 1, 32'hFFFF_FFFF);
    reqCycles = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (mem_req) begin
        reqCycles++;
        if (reqCycles == 1) begin
          checkOutput("s3_mem_addr", mem_addr, 32'h40);
          checkOutput("s3_mem_we", {31'b0, mem_we}, 32'h1);
          checkOutput("s3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
          m1_req = 1'b0;
        end
      end
      if (m1_done || m0_done) seen = 1'b1;
    end
    m1_req = 1'b0;
    checkOutput("s3_req_cycles", reqCycles, 15);

    // Scenario 4: stray ack while idle, then ack on the timeout cycle itself.
    @(negedge clk);
    ackManual = 1'b1;
    memRdata  = 32'h1111_2222;
    repeat (3) @(negedge clk);
    checkOutput("s4_idle_ack_rdata", rdata, 32'hFFFF_FFFF);
    ackManual = 1'b0;
    memRdata  = 32'h0BAD_F00D;
    applyStimulus(1, 0, 32'h200, 32'h0, 0, 0, 32'h0, 32'h0);
    pushExp(0, 0, 32'h0BAD_F00D);
    reqCycles = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (mem_req) begin
        reqCycles++;
        if (reqCycles == 2) m0_addr = 32'h300;
        if (reqCycles == 3) checkOutput("s4_addr_held", mem_addr, 32'h200);
        if (reqCycles == 15) ackManual = 1'b1;
      end
      if (m0_done || m1_done) seen = 1'b1;
    end
    ackManual = 1'b0;
    m0_req = 1'b0;
    checkOutput("s4_req_cycles", reqCycles, 15);

    // Scenario 5: build up starvation, reset mid-ACCESS, then confirm a clean restart.
    @(negedge clk);
    ackImmediate = 1'b1;
    memRdata = 32'h5555_AAAA;
    applyStimulus(1, 0, 32'h500, 32'h0, 1, 0, 32'h600, 32'h0);
    for (int i = 0; i < 3; i++) pushExp(0, 0, 32'h5555_AAAA);
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      @(negedge clk);
      if (m0_done || m1_done) n++;
    end
    ackImmediate = 1'b0;
    checkOutput("s5_pre_done_count", n, 3);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    checkOutput("s5_in_access", {31'b0, mem_req}, 32'h1);
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    checkOutput("s5_rst_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("s5_rst_m0_done", {31'b0, m0_done}, 32'h0);
    checkOutput("s5_rst_m1_done", {31'b0, m1_done}, 32'h0);
    checkOutput("s5_rst_owner", {31'b0, owner}, 32'h0);
    checkOutput("s5_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ackImmediate = 1'b1;
    memRdata = 32'h7777_0000;
    applyStimulus(1, 0, 32'h500, 32'h0, 1, 0, 32'h600, 32'h0);
    for (int i = 0; i < 5; i++) pushExp(i == 4, 0, 32'h7777_0000);
    n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      if (m0_done || m1_done) n++;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    checkOutput("s5_post_done_count", n, 5);

    repeat (4) @(negedge clk);
    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/y86_mem_arbiter.md
Y86_MEM_ARBITER -- requirements
Module: y86_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles in ACCESS awaiting mem_ack.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive M0 grants allowed while M1 waits.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0_req, m1_req  input  1 each  access request, held until matching done.
REQ-006 m0_we, m1_we  input  1 each  1 = store, 0 = load.
REQ-007 m0_addr, m1_addr  input  32 each  byte address.
REQ-008 m0_wdata, m1_wdata  input  32 each  store data.
REQ-009 m0_done, m1_done  output  1 each  one-cycle completion pulse.
REQ-010 m0_err, m1_err  output  1 each  timeout flag, valid with done.
REQ-011 rdata  output  32  load data, valid with any done.
REQ-012 mem_req, mem_we  output  1 each  memory strobe, write enable.
REQ-013 mem_addr, mem_wdata  output  32 each  memory address, write data.
REQ-014 mem_ack  input  1  memory completion; mem_rdata  input  32  load data.
REQ-015 owner  output  1  master currently granted (0 = M0 core, 1 = M1 debug/DMA).

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-017 IDLE: no request -> stay IDLE.
REQ-018 IDLE: any request -> arbitrate, latch owner, we, addr, wdata; go to ACCESS.
REQ-019 Arbitration: M0 wins unless m1_req=1 and starve_cnt==STARVE_MAX; then M1 wins.
REQ-020 starve_cnt: +1 on each M0 grant while m1_req=1; cleared on every M1 grant; saturates at STARVE_MAX.
REQ-021 ACCESS: mem_req=1; mem_we, mem_addr, mem_wdata SHALL come from the latched registers, not live inputs.
REQ-022 ACCESS with mem_ack=1: capture mem_rdata into rdata (loads only; stores keep rdata); go to DONE.
REQ-023 Timeout counter: cleared on entry to ACCESS; +1 each ACCESS cycle without ack.
REQ-024 Counter reaching TIMEOUT: go to DONE with err set; rdata = 32'hFFFFFFFF.
REQ-025 mem_ack in the same cycle as timeout expiry SHALL win: normal completion, err=0.
REQ-026 DONE: owner's done=1 for exactly one cycle; err valid the same cycle; then IDLE.
REQ-027 Minimum transaction = 3 cycles (IDLE, ACCESS, DONE), with mem_ack in the first ACCESS cycle.
REQ-028 mem_ack outside ACCESS SHALL be ignored.
REQ-029 Request dropped mid-transaction SHALL NOT abort the transaction; done still pulses.
REQ-030 Non-owner done and err SHALL stay 0 at all times.
REQ-031 Outputs SHALL be registered or decoded from state only; no combinational path from m*_req to mem_req.

Reset
REQ-032 rst=1 -> state IDLE, starve_cnt=0, timeout counter=0, owner=0.
REQ-033 rst=1 -> rdata=0 and all latched fields = 0.
REQ-034 rst=1 -> mem_req, m0_done, m1_done, m0_err, m1_err = 0 on the following edge.
REQ-035 rst in ACCESS or DONE SHALL abandon the transaction with no done pulse.
REQ-036 First arbitration after reset release SHALL occur in the next cycle.

Structure
REQ-037 Shared package y86_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), ERR_DATA = 32'hFFFFFFFF, and the owner encoding constants.
REQ-038 One sub-module, y86_arb_prio: combinational fixed-priority selection with starvation override; inputs m0_req, m1_req, starve_cnt; output grant index.
REQ-039 Counters sized $clog2(param+1) bits.

Verification
REQ-040 M0 load addr 0x100, mem_ack in first ACCESS cycle with mem_rdata=0x12345678 -> m0_done at cycle 3, rdata=0x12345678, m0_err=0.
REQ-041 m0_req and m1_req both held continuously, ack always immediate -> grant order M0,M0,M0,M0,M1, then repeats.
REQ-042 M1 store addr 0x40, wdata 0xDEADBEEF, no ack -> mem_req held 15 cycles, then m1_done=1, m1_err=1, rdata=0xFFFFFFFF.
REQ-043 mem_ack arriving in the exact cycle the timeout expires -> done with err=0 and the acked data in rdata.
REQ-044 rst asserted during ACCESS -> next cycle mem_req=0, no done pulse, starve_cnt=0, state IDLE.
REQ-045 m0_addr changed during ACCESS -> mem_addr keeps the originally latched value.
